// File: rtl/scan_sequencer_pkg.sv
// Shared types and constants for the scan sequencer: scan order, FSM state
// and the select range driven into the 3-to-8 decoder.
package scan_pkg;

  typedef enum logic [1:0] {
    SCAN_UP   = 2'd0,
    SCAN_DOWN = 2'd1,
    SCAN_PING = 2'd2
  } scan_mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } scan_state_e;

  localparam logic [2:0] SEL_MIN = 3'd0;
  localparam logic [2:0] SEL_MAX = 3'd7;

  // The unused encoding 2'b11 falls back to an up-scan.
  function automatic scan_mode_e decode_mode(input logic [1:0] m);
    case (m)
      2'b01:   return SCAN_DOWN;
      2'b10:   return SCAN_PING;
      default: return SCAN_UP;
    endcase
  endfunction

endpackage

// File: rtl/scan_sequencer_if.sv
// Handshake, configuration and decoder-select signals of the scan sequencer.
// The controller drives the master side; the sequencer is the slave.
interface scan_sequencer_if #(
  parameter int DWELL_W = 8
);
  logic               start;
  logic               stop;
  logic [1:0]         mode;
  logic               single;
  logic [DWELL_W-1:0] dwell;
  logic [2:0]         sel;
  logic               sel_en;
  logic               step;
  logic               busy;
  logic               done;

  modport master (
    output start, stop, mode, single, dwell,
    input  sel, sel_en, step, busy, done
  );

  modport slave (
    input  start, stop, mode, single, dwell,
    output sel, sel_en, step, busy, done
  );
endinterface

// File: rtl/scan_sequencer_dwell_timer.sv
// Per-value dwell counter: counts RUN cycles since the last clear and flags
// the cycle in which the count reaches the latched limit.
module dwell_timer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               run,
  input  logic [DWELL_W-1:0] limit,
  output logic               expire
);

  logic [DWELL_W-1:0] cnt_q, cnt_d;

  // Equality compare only; the counter is cleared before it can wrap.
  assign expire = run && (cnt_q == limit);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/scan_sequencer.sv
// Select generator feeding the 3-to-8 decoder: steps sel through up, down or
// ping-pong order, each value held for dwell+1 cycles, single-sweep or looping.
module scan_sequencer
  import scan_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  scan_sequencer_if.slave  bus
);

  scan_state_e        state_q, state_d;
  scan_mode_e         mode_q, mode_d;
  logic               single_q, single_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [2:0]         sel_q, sel_d;
  logic               dir_up_q, dir_up_d;
  logic               turned_q, turned_d;
  logic               step_q, step_d;
  logic               done_q, done_d;

  logic               tmr_clear;
  logic               tmr_expire;
  logic [2:0]         adv_sel;
  logic               adv_dir_up;
  logic               last_val;
  scan_mode_e         start_mode;

  dwell_timer #(.DWELL_W(DWELL_W)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (tmr_clear),
    .run    (state_q == ST_RUN),
    .limit  (dwell_q),
    .expire (tmr_expire)
  );

  assign start_mode = decode_mode(bus.mode);

  // Next value in the sequence and whether the current one ends a sweep.
  // Ping-pong flips direction on landing at an endpoint so it is not repeated;
  // turned_q records that the top was reached, marking the return to 0 as final.
  always_comb begin
    adv_sel    = sel_q + 3'd1;
    adv_dir_up = dir_up_q;
    last_val   = (sel_q == SEL_MAX);
    case (mode_q)
      SCAN_DOWN: begin
        adv_sel  = sel_q - 3'd1;
        last_val = (sel_q == SEL_MIN);
      end
      SCAN_PING: begin
        adv_sel  = dir_up_q ? sel_q + 3'd1 : sel_q - 3'd1;
        last_val = (sel_q == SEL_MIN) && turned_q;
        if (adv_sel == SEL_MAX) begin
          adv_dir_up = 1'b0;
        end else if (adv_sel == SEL_MIN) begin
          adv_dir_up = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    single_d  = single_q;
    dwell_d   = dwell_q;
    sel_d     = sel_q;
    dir_up_d  = dir_up_q;
    turned_d  = turned_q;
    step_d    = 1'b0;
    done_d    = 1'b0;
    tmr_clear = 1'b0;

    if (state_q == ST_IDLE) begin
      if (bus.start && !bus.stop) begin
        state_d   = ST_RUN;
        mode_d    = start_mode;
        single_d  = bus.single;
        dwell_d   = bus.dwell;
        sel_d     = (start_mode == SCAN_DOWN) ? SEL_MAX : SEL_MIN;
        dir_up_d  = 1'b1;
        turned_d  = 1'b0;
        step_d    = 1'b1;
        tmr_clear = 1'b1;
      end
    end else begin
      if (bus.stop) begin
        state_d   = ST_IDLE;
        tmr_clear = 1'b1;
      end else if (tmr_expire) begin
        tmr_clear = 1'b1;
        if (single_q && last_val) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          sel_d    = adv_sel;
          dir_up_d = adv_dir_up;
          turned_d = turned_q | (adv_sel == SEL_MAX);
          step_d   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      mode_q   <= SCAN_UP;
      single_q <= 1'b0;
      dwell_q  <= '0;
      sel_q    <= SEL_MIN;
      dir_up_q <= 1'b1;
      turned_q <= 1'b0;
      step_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      single_q <= single_d;
      dwell_q  <= dwell_d;
      sel_q    <= sel_d;
      dir_up_q <= dir_up_d;
      turned_q <= turned_d;
      step_q   <= step_d;
      done_q   <= done_d;
    end
  end

  assign bus.sel    = sel_q;
  assign bus.sel_en = (state_q == ST_RUN);
  assign bus.busy   = (state_q == ST_RUN);
  assign bus.step   = step_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Bench for scan_sequencer: directed vector table, hand-written corner
// sequences and randomized traffic against a sequence-index reference model.
module tb_scan_sequencer;

  localparam int DW = 8;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  scan_sequencer_if #(.DWELL_W(DW)) bus ();

  scan_sequencer #(.DWELL_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic       stop;
    logic [1:0] mode;
    logic       single;
    int         dwell;
    int         e_sel;
    logic       e_en;
    logic       e_step;
    logic       e_busy;
    logic       e_done;
  } vec_t;

  vec_t vecs[13];

  // Reference model: position in the sweep is t/(dwell+1) into an abstract list.
  logic m_run;
  int   m_t;
  int   m_mode;
  logic m_single;
  int   m_dwell;
  logic m_done;
  int   m_sel;

  int   c_step;
  int   c_busy;
  int   c_done;

  function automatic int seq_val(int mode, int idx);
    int p;
    if (mode == 1) return 7 - (idx % 8);
    if (mode == 2) begin
      p = idx % 14;
      return (p <= 7) ? p : 14 - p;
    end
    return idx % 8;
  endfunction

  function automatic int seq_len(int mode);
    return (mode == 2) ? 15 : 8;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 1'b0; m_t = 0; m_done = 1'b0; m_sel = 0;
  endtask

  task automatic model_edge(input logic s, input logic p, input logic [1:0] mode,
                            input logic single, input int dwell);
    m_done = 1'b0;
    if (!m_run) begin
      if (s && !p) begin
        m_run    = 1'b1;
        m_t      = 0;
        m_mode   = (mode == 2'b11) ? 0 : int'(mode);
        m_single = single;
        m_dwell  = dwell;
      end
    end else if (p) begin
      m_run = 1'b0;
    end else begin
      m_t++;
      if (m_single && m_t == seq_len(m_mode) * (m_dwell + 1)) begin
        m_run  = 1'b0;
        m_done = 1'b1;
      end
    end
    if (m_run) m_sel = seq_val(m_mode, m_t / (m_dwell + 1));
  endtask

  task automatic check_model();
    logic e_step;
    e_step = m_run && (m_t % (m_dwell + 1) == 0);
    chk("sel",    bus.sel,    m_sel);
    chk("sel_en", bus.sel_en, m_run);
    chk("busy",   bus.busy,   m_run);
    chk("step",   bus.step,   e_step);
    chk("done",   bus.done,   m_done);
    c_step += bus.step;
    c_busy += bus.busy;
    c_done += bus.done;
  endtask

  // Called at a falling edge: check current outputs, then drive the next inputs.
  task automatic cyc(input logic s, input logic p, input logic [1:0] mode,
                     input logic single, input int dwell);
    check_model();
    bus.start  = s;
    bus.stop   = p;
    bus.mode   = mode;
    bus.single = single;
    bus.dwell  = DW'(dwell);
    model_edge(s, p, mode, single, dwell);
    @(negedge clk);
  endtask

  task automatic clr_counts();
    c_step = 0; c_busy = 0; c_done = 0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.stop   = 1'b0;
    bus.mode   = 2'b00;
    bus.single = 1'b0;
    bus.dwell  = '0;
    model_reset();
    clr_counts();

    //            st stp mode  sgl dw  sel en step busy done
    vecs[0]  = '{1, 1, 2'b00, 1, 1,   0, 0, 0, 0, 0};
    vecs[1]  = '{1, 0, 2'b00, 1, 1,   0, 1, 1, 1, 0};
    vecs[2]  = '{0, 0, 2'b00, 1, 1,   0, 1, 0, 1, 0};
    vecs[3]  = '{0, 0, 2'b00, 1, 1,   1, 1, 1, 1, 0};
    vecs[4]  = '{0, 0, 2'b00, 1, 1,   1, 1, 0, 1, 0};
    vecs[5]  = '{1, 0, 2'b01, 0, 0,   2, 1, 1, 1, 0};
    vecs[6]  = '{0, 1, 2'b00, 1, 1,   2, 0, 0, 0, 0};
    vecs[7]  = '{1, 0, 2'b01, 0, 0,   7, 1, 1, 1, 0};
    vecs[8]  = '{0, 0, 2'b01, 0, 0,   6, 1, 1, 1, 0};
    vecs[9]  = '{0, 1, 2'b01, 0, 0,   6, 0, 0, 0, 0};
    vecs[10] = '{1, 0, 2'b11, 1, 0,   0, 1, 1, 1, 0};
    vecs[11] = '{0, 0, 2'b11, 1, 0,   1, 1, 1, 1, 0};
    vecs[12] = '{0, 1, 2'b11, 1, 0,   1, 0, 0, 0, 0};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_model();

    foreach (vecs[i]) begin
      bus.start  = vecs[i].start;
      bus.stop   = vecs[i].stop;
      bus.mode   = vecs[i].mode;
      bus.single = vecs[i].single;
      bus.dwell  = DW'(vecs[i].dwell);
      @(negedge clk);
      chk($sformatf("vec%0d.sel", i),    bus.sel,    vecs[i].e_sel);
      chk($sformatf("vec%0d.sel_en", i), bus.sel_en, vecs[i].e_en);
      chk($sformatf("vec%0d.step", i),   bus.step,   vecs[i].e_step);
      chk($sformatf("vec%0d.busy", i),   bus.busy,   vecs[i].e_busy);
      chk($sformatf("vec%0d.done", i),   bus.done,   vecs[i].e_done);
    end
    m_run = 1'b0; m_done = 1'b0; m_sel = 1;

    // Asynchronous reset in the middle of an up scan at sel=5.
    cyc(1, 0, 2'b00, 0, 3);
    for (int k = 0; k < 40 && !(m_run && m_t == 20); k++) cyc(0, 0, 2'b00, 0, 3);
    chk("pre_reset.sel", bus.sel, 5);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst.sel",    bus.sel,    0);
    chk("async_rst.sel_en", bus.sel_en, 0);
    chk("async_rst.step",   bus.step,   0);
    chk("async_rst.busy",   bus.busy,   0);
    chk("async_rst.done",   bus.done,   0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cyc(0, 0, 2'b00, 0, 0);

    // Up, single sweep, dwell=1.
    clr_counts();
    cyc(1, 0, 2'b00, 1, 1);
    for (int k = 0; k < 20; k++) cyc(0, 0, 2'b00, 1, 1);
    chk("up_single.steps", c_step, 8);
    chk("up_single.busy_cycles", c_busy, 16);
    chk("up_single.dones", c_done, 1);

    // Down, continuous, dwell=0.
    clr_counts();
    cyc(1, 0, 2'b01, 0, 0);
    for (int k = 0; k < 20; k++) cyc(0, 0, 2'b01, 0, 0);
    chk("down_cont.dones", c_done, 0);
    chk("down_cont.busy_cycles", c_busy, 20);
    cyc(0, 1, 2'b01, 0, 0);

    // Ping-pong single, then continuous.
    clr_counts();
    cyc(1, 0, 2'b10, 1, 0);
    for (int k = 0; k < 18; k++) cyc(0, 0, 2'b10, 1, 0);
    chk("ping_single.busy_cycles", c_busy, 15);
    chk("ping_single.dones", c_done, 1);
    cyc(1, 0, 2'b10, 0, 0);
    for (int k = 0; k < 40; k++) cyc(0, 0, 2'b10, 0, 0);
    cyc(0, 1, 2'b10, 0, 0);

    // Stop at sel=4 on its third dwell cycle; then start+stop together in IDLE.
    cyc(1, 0, 2'b00, 0, 5);
    for (int k = 0; k < 40 && !(m_run && m_t == 26); k++) cyc(0, 0, 2'b00, 0, 5);
    chk("pre_stop.sel", bus.sel, 4);
    cyc(0, 1, 2'b00, 0, 5);
    chk("stop.sel_en", bus.sel_en, 0);
    cyc(1, 1, 2'b00, 0, 5);
    chk("start_stop_idle.busy", bus.busy, 0);
    cyc(0, 0, 2'b00, 0, 5);

    // Start while busy and a config change mid-run must not disturb the scan.
    cyc(1, 0, 2'b00, 0, 2);
    for (int k = 0; k < 5; k++) cyc(0, 0, 2'b00, 0, 2);
    cyc(1, 0, 2'b01, 1, 7);
    for (int k = 0; k < 12; k++) cyc(0, 0, 2'b01, 1, 7);
    cyc(0, 1, 2'b00, 0, 2);

    // Randomized traffic, including back-to-back starts on done.
    for (int k = 0; k < 3000; k++) begin
      cyc(($urandom_range(0, 5) == 0) || (bus.done && $urandom_range(0, 1) == 1),
          ($urandom_range(0, 39) == 0),
          2'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)),
          $urandom_range(0, 3));
    end
    check_model();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/scan_sequencer.md
Name: scan_sequencer

Overview:
- Sequential select generator that sits directly upstream of the team's 3-to-8 decoder.
- Drives the decoder's 3-bit address and enable so that one of eight outputs (display digits, row strobes) is activated in turn, each for a programmable dwell time.
- Supports up, down and ping-pong ordering, in single-sweep or continuous operation.
- Uses a start/stop handshake with busy/done status.

Parameters:
- DWELL_W, 8, width of the dwell-count input; each select value is held for dwell+1 cycles.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a scan; sampled only in IDLE.
- stop  in  1  synchronous abort; honoured in any state.
- mode  in  2  scan order: 00 up, 01 down, 10 ping-pong, 11 treated as up. Latched on an accepted start.
- single  in  1  1 = one sweep then finish, 0 = continuous. Latched on an accepted start.
- dwell  in  DWELL_W  hold count. Latched on an accepted start.
- sel  out  3  decoder address.
- sel_en  out  1  decoder enable; high only while RUN.
- step  out  1  one-cycle pulse on the first cycle of each newly presented sel value, including the first value.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when a single sweep completes.

Behaviour:
- Clock and reset:
  - One clock.
  - Reset is asynchronous, active-low (rst_n).
  - rst_n low, at any time including mid-scan: state=IDLE, sel=0, sel_en=0, step=0, busy=0, done=0, dwell counter=0, latched config=0.
- States:
  - IDLE: accepted start moves to RUN.
  - RUN: a completed single sweep or stop moves to IDLE.
  - No other states.
- Start:
  - start=1 in IDLE with stop=0 latches mode, single and dwell.
  - The RUN cycle follows immediately: sel_en=1, busy=1, step=1.
  - Initial sel is 0 for up and ping-pong, 7 for down.
  - start while RUN is ignored.
  - start and stop together in IDLE: stop wins, state stays IDLE.
- Dwell timing:
  - The counter is cleared when sel changes and increments each RUN cycle.
  - When the counter equals the latched dwell, sel advances on the next edge.
  - Each value is therefore visible for exactly dwell+1 cycles. dwell=0 advances every cycle.
  - Width is DWELL_W with no overflow: compare by equality.
- Sequence, continuous mode:
  - up: 0..7 then 0 (mod-8 wrap).
  - down: 7..0 then 7.
  - ping-pong: 0,1..7,6..1, then 0 again; period 14 values. The direction flag flips on reaching 7 and 0, and endpoints are not repeated.
- Sequence, single mode:
  - Sweep ends after the final value's dwell expires. Final value is 7 for up, 0 for down, 0 for ping-pong (15 values).
  - On the edge that would advance past the final value: state goes to IDLE, done=1 for one cycle, sel_en=0, busy=0.
  - sel holds its last value while IDLE; it is don't-care to the decoder because sel_en=0.
- Stop:
  - stop=1 in RUN goes to IDLE on the next edge. sel_en=0, busy=0, done stays 0, and no step is generated.
  - stop coinciding with sweep completion: stop wins, so done=0.
- Config changes: changes to mode, single or dwell during RUN have no effect until the next accepted start.
- Output timing: all outputs are registered, with no combinational path from inputs to outputs.
- Back-to-back operation: start may be accepted in the same cycle done=1, since state is already IDLE in that cycle.

Decomposition:
- Package scan_pkg:
  - mode enum: SCAN_UP, SCAN_DOWN, SCAN_PING.
  - state enum: ST_IDLE, ST_RUN.
  - Constants SEL_MIN=0 and SEL_MAX=7.
- Sub-module dwell_timer (DWELL_W):
  - Inputs: clk, rst_n, clear, run, limit.
  - Output: expire.
  - The top level holds the FSM, the sel/direction register and the output flops.

Test Plan:
- Reset mid-RUN: up, dwell=3, assert rst_n low at sel=5 -> all outputs 0 immediately (asynchronous); after release, IDLE with sel=0.
- Up, single=1, dwell=1 -> sel 0..7 each held 2 cycles, step every 2 cycles (8 pulses), done pulse one cycle after sel=7's second cycle, busy high for exactly 16 cycles.
- Down, continuous, dwell=0 -> sel 7,6,..,0,7,6 each cycle; sel_en stays 1; done never asserted.
- Ping-pong, single=1, dwell=0 -> sel 0,1..7,6..0 (15 cycles), then done=1; continuous run shows 0 following 1 with period 14.
- Stop at sel=4 (up, dwell=5, third dwell cycle) -> next cycle sel_en=0, busy=0, done=0; a start in the same cycle as stop in IDLE is ignored.
- start while busy, and config changed mid-run (dwell 2->7) -> no restart; hold time stays 3 cycles until the next accepted start.
